// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin scheduler that shares one UART transmit path
//               (external combinational framer plus serial shifter) between
//               N_REQ byte requesters. Each granted byte is presented to the
//               framer for one cycle, the returned frame is captured and then
//               shifted out LSB-first, one bit per baud_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ack,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_data_length,
    input  logic                 cfg_stop_bits,
    output logic [7:0]           fr_data,
    output logic [1:0]           fr_parity_type,
    output logic                 fr_data_length,
    output logic                 fr_stop_bits,
    output logic                 fr_tx_active,
    input  logic [10:0]          fr_frame,
    output logic                 tx,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 frame_done,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    // Pointer starts at the last index so requester 0 wins the first search.
    localparam logic [IDW-1:0] c_RR_INIT    = IDW'(N_REQ - 1);
    localparam logic [3:0]     c_LEN_PARITY = 4'd11;
    localparam logic [3:0]     c_LEN_PLAIN  = 4'd10;

    state_t          r_state;
    state_t          w_next_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_grant_id;
    logic [IDW-1:0]  w_grant_idx;
    logic            w_grant_found;
    logic [IDW:0]    w_scan_sum;
    logic            w_grant;
    logic            w_last_tick;
    logic            w_cfg_has_parity;
    logic [10:0]     r_shreg;
    logic [3:0]      r_bit_cnt;
    logic [3:0]      r_frame_len;
    logic [7:0]      r_fr_data;
    logic [1:0]      r_fr_parity;
    logic            r_fr_len;
    logic            r_fr_stop;
    logic            r_frame_done;

    // Only 7-bit/2-stop and 8-bit/1-stop are legal; parity code never is an error.
    assign cfg_err          = ~(cfg_data_length ^ cfg_stop_bits);
    assign w_cfg_has_parity = cfg_parity[0] ^ cfg_parity[1];

    assign w_grant     = (r_state == S_IDLE) && w_grant_found && !cfg_err;
    assign w_last_tick = (r_state == S_SHIFT) && baud_tick
                         && (r_bit_cnt == (r_frame_len - 4'd1));

    assign fr_data        = r_fr_data;
    assign fr_parity_type = r_fr_parity;
    assign fr_data_length = r_fr_len;
    assign fr_stop_bits   = r_fr_stop;
    assign grant_id       = r_grant_id;
    assign frame_done     = r_frame_done;

    // Round-robin search: first valid requester after the pointer, with wrap.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_sum    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_scan_sum >= (IDW+1)'(N_REQ)) begin
                w_scan_sum = w_scan_sum - (IDW+1)'(N_REQ);
            end
            if (!w_grant_found && req_valid[w_scan_sum[IDW-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_sum[IDW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs; tx is forced idle outside SHIFT.
    always_comb begin
        w_next_state = r_state;
        fr_tx_active = 1'b0;
        req_ack      = '0;
        tx           = 1'b1;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_grant) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                fr_tx_active          = 1'b1;
                req_ack[r_grant_id]   = 1'b1;
                w_next_state          = S_SHIFT;
            end
            S_SHIFT: begin
                tx = r_shreg[0];
                if (w_last_tick) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                busy         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: latch byte, line config and frame length at grant time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_id  <= '0;
            r_rr_ptr    <= c_RR_INIT;
            r_fr_data   <= '0;
            r_fr_parity <= '0;
            r_fr_len    <= 1'b0;
            r_fr_stop   <= 1'b0;
            r_frame_len <= c_LEN_PLAIN;
        end else if (w_grant) begin
            r_grant_id  <= w_grant_idx;
            r_rr_ptr    <= w_grant_idx;
            r_fr_data   <= req_data[{w_grant_idx, 3'b000} +: 8];
            r_fr_parity <= cfg_parity;
            r_fr_len    <= cfg_data_length;
            r_fr_stop   <= cfg_stop_bits;
            r_frame_len <= w_cfg_has_parity ? c_LEN_PARITY : c_LEN_PLAIN;
        end
    end

    // Frame shifter: capture framer output in LOAD, shift right with 1-fill per tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg   <= '1;
            r_bit_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_shreg   <= fr_frame;
            r_bit_cnt <= '0;
        end else if ((r_state == S_SHIFT) && baud_tick) begin
            r_shreg   <= {1'b1, r_shreg[10:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end

    // One-cycle completion pulse in the cycle after the last bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_tick;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Self-checking bench for uart_tx_scheduler. A transaction-level
//               reference (round-robin pick, bit list built from the UART
//               framing rule) is compared against the DUT every cycle, plus
//               directed scenarios with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            baud_tick = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_ack;
    logic [1:0]      cfg_parity = 2'b10;
    logic            cfg_data_length = 1'b1;
    logic            cfg_stop_bits = 1'b0;
    logic [7:0]      fr_data;
    logic [1:0]      fr_parity_type;
    logic            fr_data_length;
    logic            fr_stop_bits;
    logic            fr_tx_active;
    logic [10:0]     fr_frame;
    logic            tx;
    logic            busy;
    logic [IDW-1:0]  grant_id;
    logic            frame_done;
    logic            cfg_err;

    uart_tx_scheduler #(.N_REQ(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .cfg_parity(cfg_parity), .cfg_data_length(cfg_data_length),
        .cfg_stop_bits(cfg_stop_bits),
        .fr_data(fr_data), .fr_parity_type(fr_parity_type),
        .fr_data_length(fr_data_length), .fr_stop_bits(fr_stop_bits),
        .fr_tx_active(fr_tx_active), .fr_frame(fr_frame),
        .tx(tx), .busy(busy), .grant_id(grant_id),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic legal_cfg(input logic dl, input logic sb);
        return (dl == 1'b0 && sb == 1'b1) || (dl == 1'b1 && sb == 1'b0);
    endfunction

    // External framer: start, data LSB first, optional parity, stop bits, 1-padded.
    function automatic logic [10:0] ext_framer(input logic [7:0] d, input logic [1:0] p,
                                               input logic dl, input logic sb);
        logic [10:0] f;
        int pos;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        pos  = 1;
        ones = 0;
        for (int b = 0; b < 8; b++) begin
            if (b < 7 || dl) begin
                f[pos] = d[b];
                ones   = ones + int'(d[b]);
                pos++;
            end
        end
        if (p == 2'b01) f[pos] = (ones % 2 == 0);
        else if (p == 2'b10) f[pos] = (ones % 2 == 1);
        if (sb) ; // stop bits are the 1-padding
        return f;
    endfunction

    assign fr_frame = fr_tx_active ? ext_framer(fr_data, fr_parity_type, fr_data_length, fr_stop_bits)
                                   : 11'h000;

    // ---------------- reference model ----------------
    logic        m_in_frame = 1'b0;
    logic        m_load = 1'b0;
    logic        m_done = 1'b0;
    int          m_rr = N - 1;
    int          m_gid = 0;
    logic [7:0]  m_fr_data = '0;
    logic [1:0]  m_fr_par = '0;
    logic        m_fr_len = 1'b0;
    logic        m_fr_stop = 1'b0;
    logic        m_bits[$];
    int          m_pick;
    int          m_j;
    int          m_nb;
    int          m_ones;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in_frame = 1'b0; m_load = 1'b0; m_done = 1'b0;
            m_rr = N - 1; m_gid = 0;
            m_fr_data = '0; m_fr_par = '0; m_fr_len = 1'b0; m_fr_stop = 1'b0;
            m_bits.delete();
        end else begin
            m_done = 1'b0;
            if (!m_in_frame) begin
                m_pick = -1;
                if (legal_cfg(cfg_data_length, cfg_stop_bits)) begin
                    for (int k = 1; k <= N; k++) begin
                        m_j = (m_rr + k) % N;
                        if (m_pick < 0 && req_valid[m_j]) m_pick = m_j;
                    end
                end
                if (m_pick >= 0) begin
                    m_rr = m_pick; m_gid = m_pick;
                    m_fr_data = req_data[m_pick*8 +: 8];
                    m_fr_par = cfg_parity; m_fr_len = cfg_data_length; m_fr_stop = cfg_stop_bits;
                    m_nb = cfg_data_length ? 8 : 7;
                    m_ones = 0;
                    m_bits.delete();
                    m_bits.push_back(1'b0);
                    for (int b = 0; b < m_nb; b++) begin
                        m_bits.push_back(m_fr_data[b]);
                        m_ones = m_ones + int'(m_fr_data[b]);
                    end
                    if (cfg_parity == 2'b01) m_bits.push_back(m_ones % 2 == 0);
                    else if (cfg_parity == 2'b10) m_bits.push_back(m_ones % 2 == 1);
                    m_bits.push_back(1'b1);
                    if (cfg_stop_bits) m_bits.push_back(1'b1);
                    m_in_frame = 1'b1;
                    m_load = 1'b1;
                end
            end else if (m_load) begin
                m_load = 1'b0;
            end else if (baud_tick) begin
                m_bits.delete(0);
                if (m_bits.size() == 0) begin
                    m_in_frame = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // ---------------- compare and monitor ----------------
    int   ack_log[$];
    int   done_cnt = 0;
    logic rec_bits [0:15];
    int   rec_n = 0;
    logic e_tx;

    always @(negedge clk) begin
        e_tx = (m_in_frame && !m_load && m_bits.size() > 0) ? m_bits[0] : 1'b1;
        chk("busy", busy, m_in_frame);
        chk("fr_tx_active", fr_tx_active, m_in_frame && m_load);
        chk("req_ack", req_ack, (m_in_frame && m_load) ? (32'd1 << m_gid) : 32'd0);
        chk("tx", tx, e_tx);
        chk("frame_done", frame_done, m_done);
        chk("grant_id", grant_id, m_gid);
        chk("cfg_err", cfg_err, !legal_cfg(cfg_data_length, cfg_stop_bits));
        chk("fr_data", fr_data, m_fr_data);
        chk("fr_parity_type", fr_parity_type, m_fr_par);
        chk("fr_data_length", fr_data_length, m_fr_len);
        chk("fr_stop_bits", fr_stop_bits, m_fr_stop);
        if (rst) begin
            for (int i = 0; i < N; i++) if (req_ack[i]) ack_log.push_back(i);
            if (frame_done) done_cnt++;
            if (busy && !fr_tx_active && baud_tick && rec_n < 16) begin
                rec_bits[rec_n] = tx;
                rec_n++;
            end
        end
    end

    function automatic logic [15:0] rec_pack(input int n);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < n && k < 16; k++) v[k] = rec_bits[k];
        return v;
    endfunction

    // ---------------- stimulus ----------------
    logic auto_refill = 1'b0;
    logic hold_all = 1'b0;

    task automatic step();
        logic [N-1:0] acked;
        @(negedge clk);
        acked = req_ack;
        @(posedge clk);
        #2;
        baud_tick = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                if (hold_all) req_data[i*8 +: 8] = 8'($urandom);
                else req_valid[i] = 1'b0;
            end else if (auto_refill && !req_valid[i] && $urandom_range(0, 4) == 0) begin
                req_valid[i] = 1'b1;
                req_data[i*8 +: 8] = 8'($urandom);
            end
        end
        if (auto_refill && $urandom_range(0, 19) == 0) begin
            cfg_parity = 2'($urandom_range(0, 3));
            cfg_data_length = 1'($urandom_range(0, 1));
            cfg_stop_bits = ($urandom_range(0, 3) == 0) ? cfg_data_length : ~cfg_data_length;
        end
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 1000) begin
            step();
            n++;
        end
        chk(name, done_cnt > start, 1'b1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_fr_tx_active", fr_tx_active, 1'b0);
        @(posedge clk); #2;

        // T1: single requester 2, 0x55, even parity, 8-bit, 1 stop
        cfg_parity = 2'b10; cfg_data_length = 1'b1; cfg_stop_bits = 1'b0;
        ack_log.delete(); rec_n = 0;
        req_data[23:16] = 8'h55; req_valid[2] = 1'b1;
        @(negedge clk); chk("t1_no_early_ack", req_ack, 0);
        @(negedge clk); chk("t1_ack", req_ack, 4'b0100);
        @(posedge clk); #2; req_valid[2] = 1'b0;
        wait_done("t1_done_seen");
        chk("t1_nbits", rec_n, 11);
        chk("t1_bits", rec_pack(11), 11'b10010101010);
        chk("t1_ack_count", ack_log.size(), 1);
        chk("t1_grant_id", grant_id, 2);

        // T3: parity none, 7-bit, 2 stop, 0x41 from requester 0
        cfg_parity = 2'b00; cfg_data_length = 1'b0; cfg_stop_bits = 1'b1;
        rec_n = 0;
        req_data[7:0] = 8'h41; req_valid[0] = 1'b1;
        wait_done("t3_done_seen");
        chk("t3_nbits", rec_n, 10);
        chk("t3_bits", rec_pack(10), 10'b1110000010);

        // T4: illegal cfg blocks grants; legal cfg grants on the next edge
        cfg_parity = 2'b01; cfg_data_length = 1'b1; cfg_stop_bits = 1'b1;
        ack_log.delete();
        req_data[7:0] = 8'h9E; req_valid[0] = 1'b1;
        repeat (10) step();
        chk("t4_no_ack", ack_log.size(), 0);
        chk("t4_cfg_err", cfg_err, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_tx", tx, 1'b1);
        cfg_stop_bits = 1'b0;
        @(posedge clk); #1;
        chk("t4_grant_load", fr_tx_active, 1'b1);
        chk("t4_grant_ack", req_ack, 4'b0001);
        #1 req_valid[0] = 1'b0;
        wait_done("t4_done_seen");

        // T6: cfg and data change mid-frame do not disturb the frame in flight
        cfg_parity = 2'b10; cfg_data_length = 1'b1; cfg_stop_bits = 1'b0;
        rec_n = 0;
        req_data[15:8] = 8'hA3; req_valid[1] = 1'b1;
        n = 0;
        while (!(busy && !fr_tx_active) && n < 20) begin step(); n++; end
        chk("t6_shifting", busy && !fr_tx_active, 1'b1);
        cfg_parity = 2'b01; cfg_data_length = 1'b0; cfg_stop_bits = 1'b1;
        req_data[15:8] = 8'h3C; req_valid[1] = 1'b1;
        wait_done("t6_done1_seen");
        chk("t6_bits1", rec_pack(11), 11'b10101000110);
        rec_n = 0;
        n = 0;
        while (!fr_tx_active && n < 20) begin step(); n++; end
        chk("t6_par2", fr_parity_type, 2'b01);
        chk("t6_data2", fr_data, 8'h3C);
        chk("t6_len2", fr_data_length, 1'b0);
        wait_done("t6_done2_seen");
        chk("t6_bits2", rec_pack(11), 11'b11101111000);

        // T5: reset during bit 4 aborts; pending requesters regranted from index 0
        cfg_parity = 2'b10; cfg_data_length = 1'b1; cfg_stop_bits = 1'b0;
        req_data = 32'h11_22_33_44;
        req_valid = 4'b1110;
        step();
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        rec_n = 0;
        n = 0;
        while (rec_n < 4 && n < 200) begin step(); n++; end
        chk("t5_reached_bit4", rec_n >= 4, 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_async_tx", tx, 1'b1);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_gid", grant_id, 0);
        repeat (3) step();
        ack_log.delete();
        rst = 1'b1;
        n = 0;
        while (ack_log.size() == 0 && n < 50) begin step(); n++; end
        chk("t5_regrant", (ack_log.size() > 0) ? ack_log[0] : 99, 1);
        wait_done("t5_done1_seen");
        wait_done("t5_done2_seen");
        chk("t5_second", (ack_log.size() > 1) ? ack_log[1] : 99, 3);

        // T2: all requesters held -> 0,1,2,3,0
        ack_log.delete();
        hold_all = 1'b1;
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) wait_done("t2_done_seen");
        for (int f = 0; f < 5; f++)
            chk("t2_rr_order", (ack_log.size() > f) ? ack_log[f] : 99, f % N);
        hold_all = 1'b0;
        req_valid = '0;

        // Random phase
        auto_refill = 1'b1;
        repeat (4000) step();
        auto_refill = 1'b0;
        repeat (300) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
